// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states,
// divide-by-zero LO fill value and a small op decode helper.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;
    localparam logic [2:0] MDU_MFHI  = 3'd6;
    localparam logic [2:0] MDU_MFLO  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } mdu_state_e;

    // LO after a divide by zero is this bit replicated across the register.
    localparam logic MDU_DIVZ_LO_FILL = 1'b1;

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_iterative_if.sv
// EX-stage <-> MDU signal bundle. The master is the pipeline, the slave is the MDU.
interface mdu_iterative_if
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
);
    // Handshake: an op is taken on a rising edge when op_valid_i=1, stall_o=0 and
    // flush_i=0; stall_o is the inverse of ready and the pipeline holds EX while it is 1.
    logic             op_valid_i;
    logic [2:0]       op_i;
    logic [WIDTH-1:0] rs_data_i;
    logic [WIDTH-1:0] rt_data_i;
    logic             flush_i;
    logic             stall_o;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
    logic [WIDTH-1:0] mf_data_o;
    mdu_state_e       state_dbg;

    modport master (
        output op_valid_i, op_i, rs_data_i, rt_data_i, flush_i,
        input  stall_o, busy_o, done_o, hi_o, lo_o, mf_data_o, state_dbg
    );

    modport slave (
        input  op_valid_i, op_i, rs_data_i, rt_data_i, flush_i,
        output stall_o, busy_o, done_o, hi_o, lo_o, mf_data_o, state_dbg
    );
endinterface

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate; gives |x| for operands and restores result signs.
module mdu_sign_fix #(
    parameter int N = 32
) (
    input  logic [N-1:0] value,
    input  logic         negate,
    output logic [N-1:0] result
);
    assign result = negate ? ((~value) + N'(1)) : value;
endmodule

// File: rtl/mdu_iterative.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO and MT/MF access for the EX stage.
// Optional macro MDU_EARLY_OUT_EN: early MUL exit on zero multiplier bits, direct DIV-by-zero.
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic            CLOCK,
    input logic            RESET,
    mdu_iterative_if.slave bus
);

    mdu_state_e         state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] prod, mcand, prod_fixed;
    logic [WIDTH-1:0]   mplier, rem, quo, dvsr;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [WIDTH-1:0]   abs_rs, abs_rt, quo_fixed, rem_fixed;
    logic [WIDTH:0]     rem_sh, trial;
    logic               neg_lo, neg_hi, div_zero, is_div, done_q;
    logic               accept_mul, accept_div, write_mthi, write_mtlo, fix_write;
    logic               mul_last, div_last, busy;
    logic               rs_neg, rt_neg, rt_zero;

    assign rs_neg  = op_is_signed(bus.op_i) & bus.rs_data_i[WIDTH-1];
    assign rt_neg  = op_is_signed(bus.op_i) & bus.rt_data_i[WIDTH-1];
    assign rt_zero = (bus.rt_data_i == '0);

    mdu_sign_fix #(.N(WIDTH))   u_abs_rs  (.value(bus.rs_data_i), .negate(rs_neg), .result(abs_rs));
    mdu_sign_fix #(.N(WIDTH))   u_abs_rt  (.value(bus.rt_data_i), .negate(rt_neg), .result(abs_rt));
    mdu_sign_fix #(.N(2*WIDTH)) u_fix_prd (.value(prod), .negate(neg_lo), .result(prod_fixed));
    mdu_sign_fix #(.N(WIDTH))   u_fix_quo (.value(quo),  .negate(neg_lo), .result(quo_fixed));
    mdu_sign_fix #(.N(WIDTH))   u_fix_rem (.value(rem),  .negate(neg_hi), .result(rem_fixed));

`ifdef MDU_EARLY_OUT_EN
    // Stop once the bit consumed this cycle is the last non-zero multiplier bit.
    assign mul_last = (cnt == CNT_W'(1)) || (mplier[WIDTH-1:1] == '0);
`else
    assign mul_last = (cnt == CNT_W'(1));
`endif
    assign div_last = (cnt == CNT_W'(1));

    // Restoring step: shift next dividend bit into the partial remainder, trial subtract.
    assign rem_sh = {rem, quo[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, dvsr};

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        accept_mul = 1'b0;
        accept_div = 1'b0;
        write_mthi = 1'b0;
        write_mtlo = 1'b0;
        fix_write  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.op_valid_i && !bus.flush_i) begin
                    case (bus.op_i)
                        MDU_MULT, MDU_MULTU: begin
                            accept_mul = 1'b1;
                            state_nxt  = ST_MUL;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            accept_div = 1'b1;
                            state_nxt  = ST_DIV;
`ifdef MDU_EARLY_OUT_EN
                            if (rt_zero) state_nxt = ST_FIX;
`endif
                        end
                        MDU_MTHI: write_mthi = 1'b1;
                        MDU_MTLO: write_mtlo = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (bus.flush_i)   state_nxt = ST_IDLE;
                else if (mul_last) state_nxt = ST_FIX;
            end
            ST_DIV: begin
                if (bus.flush_i)   state_nxt = ST_IDLE;
                else if (div_last) state_nxt = ST_FIX;
            end
            ST_FIX: begin
                state_nxt = ST_IDLE;
                fix_write = !bus.flush_i;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            cnt      <= '0;
            prod     <= '0;
            mcand    <= '0;
            mplier   <= '0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            is_div   <= 1'b0;
        end else begin
            if (accept_mul || accept_div) begin
                cnt      <= CNT_W'(WIDTH);
                neg_lo   <= rs_neg ^ rt_neg;
                neg_hi   <= rs_neg;
                div_zero <= rt_zero;
                is_div   <= accept_div;
            end
            if (accept_mul) begin
                prod   <= '0;
                mcand  <= {{WIDTH{1'b0}}, abs_rs};
                mplier <= abs_rt;
            end
            if (accept_div) begin
`ifdef MDU_EARLY_OUT_EN
                // Skipping the iterations, so preload what they would leave in the remainder.
                rem <= rt_zero ? abs_rs : '0;
`else
                rem <= '0;
`endif
                quo  <= abs_rs;
                dvsr <= abs_rt;
            end
            if (state == ST_MUL) begin
                if (mplier[0]) prod <= prod + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - CNT_W'(1);
            end
            if (state == ST_DIV) begin
                if (!trial[WIDTH]) begin
                    rem <= trial[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b1};
                end else begin
                    rem <= rem_sh[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b0};
                end
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= fix_write;
            if (fix_write) begin
                if (is_div) begin
                    hi_q <= rem_fixed;
                    lo_q <= div_zero ? {WIDTH{MDU_DIVZ_LO_FILL}} : quo_fixed;
                end else begin
                    {hi_q, lo_q} <= prod_fixed;
                end
            end else if (write_mthi) begin
                hi_q <= bus.rs_data_i;
            end else if (write_mtlo) begin
                lo_q <= bus.rs_data_i;
            end
        end
    end

    assign busy          = (state != ST_IDLE);
    assign bus.busy_o    = busy;
    assign bus.stall_o   = bus.op_valid_i & busy;
    assign bus.done_o    = done_q;
    assign bus.hi_o      = hi_q;
    assign bus.lo_o      = lo_q;
    assign bus.state_dbg = state;

    always_comb begin
        bus.mf_data_o = '0;
        case (bus.op_i)
            MDU_MFHI: bus.mf_data_o = hi_q;
            MDU_MFLO: bus.mf_data_o = lo_q;
            default:  bus.mf_data_o = '0;
        endcase
    end

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Parametrised iterative multiply/divide unit with HI/LO registers, attached beside the ALU in the EX stage of the pipelined MIPS core.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles (shift-add / restoring divide) and serves MTHI/MTLO/MFHI/MFLO.
- Raises a stall request so the hazard logic freezes PC, IF/ID and ID/EX while an HI/LO-dependent instruction waits.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be ≥4 and even.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- CLOCK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- op_valid_i  in  1  EX-stage instruction is an MDU op
- op_i  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO
- rs_data_i  in  WIDTH  forwarded Rs value (multiplicand / dividend / MT source)
- rt_data_i  in  WIDTH  forwarded Rt value (multiplier / divisor)
- flush_i  in  1  abort the in-flight operation
- stall_o  out  1  op_valid_i & busy; pipeline must hold EX
- busy_o  out  1  iteration in progress
- done_o  out  1  one-cycle pulse when HI/LO are updated by MULT/DIV
- hi_o  out  WIDTH  HI register
- lo_o  out  WIDTH  LO register
- mf_data_o  out  WIDTH  combinational: hi_o for op 6, lo_o for op 7, else 0

Behaviour:
- Reset (async, any state): state IDLE; hi_o, lo_o, counter and datapath = 0; busy_o, done_o, stall_o = 0.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE + op_valid_i, ops 0–3:
  - Accept at the edge and latch |operands|: absolute value for signed ops, raw for unsigned.
  - Latch result signs: product sign = rs^rt; quotient sign = rs^rt; remainder sign = rs.
  - Counter = WIDTH; go to MUL or DIV.
- IDLE + op 4/5: write hi_o/lo_o at the edge, single cycle, no stall.
- IDLE + op 6/7: mf_data_o is valid in the same cycle, no stall.
- MUL: one multiplier bit per cycle into a 2·WIDTH accumulator; counter decrements; at 0 go to FIX.
- DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit); at counter 0 go to FIX.
- FIX: apply sign correction; write {hi_o, lo_o} (MUL: hi = upper product, lo = lower product; DIV: lo = quotient, hi = remainder); pulse done_o; go to IDLE.
- Latency: accept → HI/LO visible = WIDTH+1 edges; busy_o high for those WIDTH+1 cycles, low in the cycle done_o is seen.
- Any op_valid_i while busy_o: stall_o = 1, the op is not accepted, and there is no side effect. The op is accepted in the first cycle busy_o is low (same cycle as done_o); MF then returns the new value.
- Divide by zero: lo = all ones, hi = dividend (raw rs); still WIDTH+1 cycles.
- Signed MIN / −1: lo = MIN, hi = 0; no trap.
- flush_i:
  - In MUL/DIV/FIX: return to IDLE next edge; hi/lo unchanged; no done_o.
  - In IDLE: flush_i has priority over op_valid_i (the op is dropped).
- op_valid_i and flush_i in the same busy cycle: flush wins, and stall_o is still driven for that cycle.

Optional Feature:
- Macro MDU_EARLY_OUT_EN.
- Defined:
  - MUL goes to FIX as soon as the remaining multiplier bits are all zero, minimum 1 iteration.
  - DIV with zero divisor goes IDLE→FIX directly (2-cycle latency).
  - done_o still pulses exactly once.
- Undefined: fixed WIDTH+1 latency for every op, and the counter is the only exit condition.

Decomposition:
- Shared package mdu_pkg:
  - op encodings MDU_MULT … MDU_MFLO (3-bit localparams)
  - state encoding (IDLE/MUL/DIV/FIX)
  - divide-by-zero LO constant
- One natural sub-module: mdu_sign_fix, a combinational abs/negate of operands and 2·WIDTH results, instantiated at input latch and FIX.

Test Plan:
- MULT rs=−3 (0xFFFFFFFD), rt=7 → after 33 edges hi=0xFFFFFFFF, lo=0xFFFFFFEB, done_o one cycle, busy_o high 33 cycles.
- DIVU rs=100, rt=7 then MFLO/MFHI issued one cycle after accept → stall_o high until done; mf_data_o 14 then 2.
- DIV rs=−7, rt=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1); DIV rs=5, rt=0 → lo=0xFFFFFFFF, hi=5.
- MTHI 0x1234 then MTLO 0xABCD in consecutive cycles (idle) → no stall; MFHI=0x1234, MFLO=0xABCD next cycles.
- MULT 6×6 with flush_i at cycle 10 → IDLE next edge, hi/lo keep prior values, no done_o. Repeat with RESET asserted mid-DIV → all outputs 0 immediately.
- MDU_EARLY_OUT_EN: MULTU rs=9, rt=3 → done_o within 3 edges, lo=27, hi=0; DIV by 0 → done in 2 edges.
